// File: rtl/dispatch_router.sv
// Issue-stage dispatcher: steers one decoded request per cycle into a per-unit FIFO
// selected by ex_type, retiring NOPs and empty-mask requests, with perf counters.
module dispatch_router #(
    parameter  int unsigned NUM_UNITS   = 5,
    parameter  int unsigned EX_BITS     = 3,
    parameter  int unsigned DATAW       = 64,
    parameter  int unsigned NUM_THREADS = 4,
    parameter  int unsigned DEPTH       = 2,
    localparam int unsigned NT_BITS     = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int unsigned CNTW        = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [EX_BITS-1:0]               in_ex_type,
    input  logic [NUM_THREADS-1:0]           in_tmask,
    input  logic [DATAW-1:0]                 in_data,
    output logic [NUM_UNITS-1:0]             out_valid,
    input  logic [NUM_UNITS-1:0]             out_ready,
    output logic [NUM_UNITS*DATAW-1:0]       out_data,
    output logic [NUM_UNITS*NUM_THREADS-1:0] out_tmask,
    output logic [NUM_UNITS*NT_BITS-1:0]     out_tid,
    output logic [NUM_UNITS*CNTW-1:0]        occupancy,
    output logic [31:0]                      stall_cnt,
    output logic [31:0]                      nop_cnt
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [DATAW-1:0]       data;
        logic [NUM_THREADS-1:0] tmask;
        logic [NT_BITS-1:0]     tid;
    } entry_t;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    logic [NT_BITS-1:0]   w_tid;
    logic [NUM_UNITS-1:0] w_full;
    logic                 w_sel_full;
    logic                 w_nop;
    logic                 w_dispatch;
    entry_t               w_entry;
    logic [31:0]          r_stall;
    logic [31:0]          r_nop;

    // Lowest set bit of the mask becomes the head thread id.
    always_comb begin
        w_tid = '0;
        for (int i = int'(NUM_THREADS) - 1; i >= 0; i--) begin
            if (in_tmask[i]) w_tid = NT_BITS'(i);
        end
    end

    always_comb begin
        w_sel_full = 1'b0;
        for (int u = 0; u < int'(NUM_UNITS); u++) begin
            if (32'(in_ex_type) == 32'(u)) w_sel_full = w_full[u];
        end
    end

    // Readiness depends only on registered occupancy, never on out_ready.
    assign w_nop      = (32'(in_ex_type) >= NUM_UNITS) || (in_tmask == '0);
    assign in_ready   = reset && (w_nop || !w_sel_full);
    assign w_dispatch = in_valid && in_ready && !w_nop;
    assign w_entry    = '{data: in_data, tmask: in_tmask, tid: w_tid};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
            r_nop   <= '0;
        end else begin
            if (in_valid && !in_ready) r_stall <= r_stall + 32'd1;
            if (in_valid && in_ready && w_nop) r_nop <= r_nop + 32'd1;
        end
    end

    assign stall_cnt = r_stall;
    assign nop_cnt   = r_nop;

    for (genvar u = 0; u < int'(NUM_UNITS); u++) begin : g_unit
        entry_t          r_mem [DEPTH];
        logic [PTRW-1:0] r_rd;
        logic [PTRW-1:0] r_wr;
        logic [CNTW-1:0] r_cnt;
        logic            w_push;
        logic            w_pop;

        assign w_push    = w_dispatch && (32'(in_ex_type) == 32'(u));
        assign w_pop     = (r_cnt != '0) && out_ready[u];
        assign w_full[u] = (r_cnt == CNTW'(DEPTH));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_rd  <= '0;
                r_wr  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wr <= ptr_inc(r_wr);
                if (w_pop)  r_rd <= ptr_inc(r_rd);
                if (w_push && !w_pop)      r_cnt <= r_cnt + CNTW'(1);
                else if (!w_push && w_pop) r_cnt <= r_cnt - CNTW'(1);
            end
        end

        // Storage needs no reset: contents are only visible while r_cnt is nonzero.
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr] <= w_entry;
        end

        assign out_valid[u]                           = (r_cnt != '0);
        assign out_data[u*DATAW +: DATAW]             = r_mem[r_rd].data;
        assign out_tmask[u*NUM_THREADS +: NUM_THREADS] = r_mem[r_rd].tmask;
        assign out_tid[u*NT_BITS +: NT_BITS]          = r_mem[r_rd].tid;
        assign occupancy[u*CNTW +: CNTW]              = r_cnt;
    end

endmodule

// File: tb/tb_dispatch_router.sv
// Self-checking bench for dispatch_router: queue-based reference model compared every
// cycle, plus hand-computed literal checks for the directed scenarios.
module tb_dispatch_router;

    localparam int NU = 5;
    localparam int EB = 3;
    localparam int DW = 64;
    localparam int NT = 4;
    localparam int D  = 2;
    localparam int TB = 2;
    localparam int CW = 2;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [EB-1:0]     in_ex_type;
    logic [NT-1:0]     in_tmask;
    logic [DW-1:0]     in_data;
    logic [NU-1:0]     out_valid;
    logic [NU-1:0]     out_ready;
    logic [NU*DW-1:0]  out_data;
    logic [NU*NT-1:0]  out_tmask;
    logic [NU*TB-1:0]  out_tid;
    logic [NU*CW-1:0]  occupancy;
    logic [31:0]       stall_cnt;
    logic [31:0]       nop_cnt;

    int checks   = 0;
    int failures = 0;

    dispatch_router #(
        .NUM_UNITS(NU), .EX_BITS(EB), .DATAW(DW), .NUM_THREADS(NT), .DEPTH(D)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ex_type(in_ex_type),
        .in_tmask(in_tmask), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tmask(out_tmask), .out_tid(out_tid), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .nop_cnt(nop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per unit, plain counters.
    logic [DW-1:0] mq_data [NU][$];
    logic [NT-1:0] mq_tm   [NU][$];
    logic [31:0]   m_stall;
    logic [31:0]   m_nop;
    bit            m_pop [NU];
    bit            m_acc;
    int            m_t;

    function automatic int low_bit(input logic [NT-1:0] m);
        for (int i = 0; i < NT; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic bit is_nop(input logic [EB-1:0] t, input logic [NT-1:0] m);
        return (int'(t) >= NU) || (m == 0);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int u = 0; u < NU; u++) begin
                mq_data[u].delete();
                mq_tm[u].delete();
            end
            m_stall = 0;
            m_nop   = 0;
        end else begin
            m_t   = int'(in_ex_type);
            m_acc = 0;
            for (int u = 0; u < NU; u++) m_pop[u] = (mq_data[u].size() > 0) && out_ready[u];
            if (in_valid) begin
                if (is_nop(in_ex_type, in_tmask)) m_nop++;
                else if (mq_data[m_t].size() < D) m_acc = 1;
                else m_stall++;
            end
            for (int u = 0; u < NU; u++) begin
                if (m_pop[u]) begin
                    void'(mq_data[u].pop_front());
                    void'(mq_tm[u].pop_front());
                end
            end
            if (m_acc) begin
                mq_data[m_t].push_back(in_data);
                mq_tm[m_t].push_back(in_tmask);
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        bit exp_rdy;
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("m_valid%0d", u), 64'(out_valid[u]), 64'(mq_data[u].size() > 0));
            chk($sformatf("m_occ%0d", u), 64'(occupancy[u*CW +: CW]), 64'(mq_data[u].size()));
            if (mq_data[u].size() > 0) begin
                chk($sformatf("m_data%0d", u), out_data[u*DW +: DW], mq_data[u][0]);
                chk($sformatf("m_tmask%0d", u), 64'(out_tmask[u*NT +: NT]), 64'(mq_tm[u][0]));
                chk($sformatf("m_tid%0d", u), 64'(out_tid[u*TB +: TB]), 64'(low_bit(mq_tm[u][0])));
            end
        end
        if (in_valid) begin
            if (!reset) exp_rdy = 0;
            else if (is_nop(in_ex_type, in_tmask)) exp_rdy = 1;
            else exp_rdy = mq_data[int'(in_ex_type)].size() < D;
            chk("m_in_ready", 64'(in_ready), 64'(exp_rdy));
        end
        chk("m_stall", 64'(stall_cnt), 64'(m_stall));
        chk("m_nop", 64'(nop_cnt), 64'(m_nop));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int t, input logic [NT-1:0] m, input logic [DW-1:0] d);
        in_valid   = v;
        in_ex_type = EB'(t);
        in_tmask   = m;
        in_data    = d;
    endtask

    initial begin
        int k;
        reset     = 1'b0;
        out_ready = '0;
        drive(1, 2, 4'b0001, 64'h1);

        // Reset held with a pending request.
        repeat (3) step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_nop", 64'(nop_cnt), 64'd0);
        drive(0, 0, 0, 0);
        reset = 1'b1;
        step();

        // Single dispatch to unit 2.
        drive(1, 2, 4'b0100, 64'hABCD);
        step();
        drive(0, 0, 0, 0);
        chk("single_valid", 64'(out_valid), 64'b00100);
        chk("single_data", out_data[2*DW +: DW], 64'hABCD);
        chk("single_tid", 64'(out_tid[2*TB +: TB]), 64'd2);
        chk("single_occ", 64'(occupancy[2*CW +: CW]), 64'd1);

        // Backpressure on unit 0.
        drive(1, 0, 4'b0110, 64'h1);
        chk("bp_first_ready", 64'(in_ready), 64'd1);
        step();
        drive(1, 0, 4'b0110, 64'h2);
        step();
        drive(1, 0, 4'b1000, 64'h3);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        repeat (3) step();
        chk("bp_stall3", 64'(stall_cnt), 64'd3);
        out_ready[0] = 1'b1;
        chk("bp_no_comb_ready", 64'(in_ready), 64'd0);
        step();
        chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
        chk("bp_stall4", 64'(stall_cnt), 64'd4);
        chk("bp_head2", out_data[0 +: DW], 64'h2);
        step();
        drive(0, 0, 0, 0);
        chk("bp_head3", out_data[0 +: DW], 64'h3);
        chk("bp_tid3", 64'(out_tid[0 +: TB]), 64'd3);
        repeat (2) step();
        chk("bp_drained", 64'(out_valid[0]), 64'd0);

        // NOPs: out-of-range type, then empty mask.
        drive(1, 7, 4'b0001, 64'hDEAD);
        chk("nop_type_ready", 64'(in_ready), 64'd1);
        step();
        drive(1, 1, 4'b0000, 64'hBEEF);
        chk("nop_mask_ready", 64'(in_ready), 64'd1);
        step();
        drive(0, 0, 0, 0);
        chk("nop_cnt2", 64'(nop_cnt), 64'd2);
        chk("nop_no_valid", 64'(out_valid[1]), 64'd0);

        // Streaming to unit 3 with all consumers ready.
        out_ready = '1;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 3, 4'b1010, 64'(100 + i));
            step();
            chk("stream_occ_le1", 64'(occupancy[3*CW +: CW] <= 1), 64'd1);
            if (out_valid[3]) begin
                chk("stream_data", out_data[3*DW +: DW], 64'(100 + k));
                k++;
            end
        end
        drive(0, 0, 0, 0);
        step();
        chk("stream_count", 64'(k), 64'd16);
        chk("stream_empty", 64'(out_valid[3]), 64'd0);

        // Reset while unit 1 is full.
        out_ready = 5'b11101;
        drive(1, 1, 4'b1000, 64'h11);
        step();
        drive(1, 1, 4'b1000, 64'h22);
        step();
        drive(0, 0, 0, 0);
        chk("mid_full", 64'(occupancy[1*CW +: CW]), 64'd2);
        reset = 1'b0;
        #1;
        chk("mid_valid0", 64'(out_valid), 64'd0);
        chk("mid_occ0", 64'(occupancy), 64'd0);
        step();
        reset = 1'b1;
        drive(1, 1, 4'b0110, 64'h5555);
        step();
        drive(0, 0, 0, 0);
        chk("mid_new_valid", 64'(out_valid[1]), 64'd1);
        chk("mid_new_data", out_data[1*DW +: DW], 64'h5555);
        chk("mid_new_tid", 64'(out_tid[1*TB +: TB]), 64'd1);
        out_ready[1] = 1'b1;
        step();
        chk("mid_no_stale", 64'(out_valid[1]), 64'd0);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
